// File: rtl/multi_tickgen.sv
// Multi-channel runtime-programmable tick generator with a free-running sweep counter.
// Optional one-shot mode per channel: define MULTI_TICKGEN_ONESHOT_EN.
module multi_tickgen #(
  parameter int                    NUM_CH     = 3,
  parameter int                    CNT_W      = 27,
  parameter logic [NUM_CH*CNT_W-1:0] RESET_DIVS = {27'd100_000_000, 27'd333_334, 27'd16_777_216},
  parameter int                    FREE_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef MULTI_TICKGEN_ONESHOT_EN
  input  logic [NUM_CH-1:0] oneshot,
  output logic [NUM_CH-1:0] done,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [FREE_W-1:0] free_cnt,
  output logic              free_wrap
);

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  div [NUM_CH];
  logic [CNT_W-1:0]  dm1 [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] halt;

  // A divisor of 0 behaves as 1, so the terminal count is clamped at 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dm1[i]    = (div[i] == '0) ? '0 : div[i] - CNT_W'(1);
      wr_hit[i] = wr_en && (wr_sel == 3'(i));
    end
  end

`ifdef MULTI_TICKGEN_ONESHOT_EN
  // Halt once the single tick has been issued, and stay halted while done is set.
  assign halt = oneshot & (done | tick);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync || wr_hit[i] || !oneshot[i]) begin
          done[i] <= 1'b0;
        end else if (tick[i]) begin
          done[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign halt = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= RESET_DIVS[i*CNT_W +: CNT_W];
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync || wr_hit[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          if (sync)      sq[i]  <= 1'b0;
          if (wr_hit[i]) div[i] <= wr_div;
        end else if (halt[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (en[i]) begin
          if (cnt[i] == dm1[i]) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
            sq[i]   <= ~sq[i];
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

  // The wrap strobe is registered alongside the count so it coincides with free_cnt==0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_cnt  <= '0;
      free_wrap <= 1'b0;
    end else begin
      free_cnt  <= free_cnt + FREE_W'(1);
      free_wrap <= &free_cnt;
    end
  end

endmodule

// File: doc/multi_tickgen.md
Name: multi_tickgen

Overview:
- Parametrised, runtime-programmable tick generator for the light-cycle display/game logic.
- Provides NUM_CH independent divider channels. Each channel outputs a one-cycle strobe and a 50% duty square wave.
- Also provides a free-running power-of-two sweep counter with a wrap strobe.
- Replaces per-rate hard-coded counters. Game, segment-scan and seconds timing all derive from one block with runtime-loadable rates and a common phase-sync input.

Parameters:
- NUM_CH, 3, number of divider channels (1..8).
- CNT_W, 27, width of each channel counter and divisor.
- RESET_DIVS, {27'd100_000_000, 27'd333_334, 27'd16_777_216}, packed NUM_CH*CNT_W reset divisors; channel i occupies bits [i*CNT_W +: CNT_W].
- FREE_W, 24, width of free-running sweep counter.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-low reset
- en  input  NUM_CH  per-channel run enable
- sync  input  1  synchronous phase-align strobe, all channels
- wr_en  input  1  divisor write strobe
- wr_sel  input  3  channel index for write
- wr_div  input  CNT_W  divisor value, period in clk cycles
- tick  output  NUM_CH  one-cycle strobe per channel (registered)
- sq  output  NUM_CH  square wave per channel, period 2*div (registered)
- free_cnt  output  FREE_W  free-running counter value
- free_wrap  output  1  one-cycle strobe when free_cnt wraps to 0 (registered)

Behaviour:
- Reset (rst=0, async):
  - all cnt=0, div=RESET_DIVS, free_cnt=0.
  - tick=0, sq=0, free_wrap=0.
- Divisor rule: effective divisor d = max(div,1). div=0 behaves as 1.
- Channel i, en[i]=1, no sync/write:
  - if cnt==d-1: cnt<=0, tick[i]<=1, sq[i]<=~sq[i]; else cnt<=cnt+1, tick[i]<=0.
  - Period d cycles. First tick is high in the cycle after cnt==d-1, i.e. d cycles after a count start at 0.
  - d=1: tick held high continuously; sq toggles every cycle.
- en[i]=0: cnt and sq hold; tick[i]<=0. Re-enable resumes from the held cnt.
- Write (wr_en=1, wr_sel<NUM_CH):
  - div[wr_sel]<=wr_div, cnt<=0, tick<=0; sq holds.
  - New period counts from the next cycle.
  - wr_sel>=NUM_CH: ignored, no state change.
- sync=1: every cnt<=0, tick<=0, sq<=0, regardless of en. free_cnt is unaffected.
- sync and wr_en in the same cycle: both apply — divisor loads and all counters and sq clear.
- Arithmetic: counters are unsigned CNT_W bits. The compare uses d-1, so no overflow; the counter never exceeds d-1.
- Free counter: free_cnt<=free_cnt+1 every cycle, wrapping modulo 2^FREE_W. free_wrap<=1 in the cycle free_cnt becomes 0 (after 2^FREE_W-1), else 0. Not affected by en, sync or writes.
- All outputs are flop-driven; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULTI_TICKGEN_ONESHOT_EN.
- With the macro defined:
  - adds input oneshot[NUM_CH] and output done[NUM_CH], both registered; done resets to 0.
  - When oneshot[i]=1, the channel emits exactly one tick, then sets done[i]=1 and halts: cnt=0, sq holds, no further ticks.
  - Write to channel i or sync clears done[i] and rearms the channel.
  - Clearing oneshot[i] while done[i]=1 also clears done and resumes periodic counting from 0.
- Without the macro: ports are absent and all channels are always periodic.

Test Plan:
- Reset, then release with RESET_DIVS defaults; force div1=4 via write -> tick[1] high at cycles 4,8,12 after write; sq[1] toggles at each; tick[0] stays 0 for 1000 cycles.
- Write div=1 to ch2 -> tick[2] continuously high from 1 cycle after write; sq[2] alternates every cycle. Write div=0 -> identical behaviour.
- ch0 div=5, drop en[0] for 3 cycles at cnt=2 -> next tick delayed exactly 3 cycles; tick stays 0 while disabled.
- Divisors 3 and 7 running, assert sync at random time -> both channels tick together at 21 cycles after sync (LCM); sq all 0 cycle after sync. Same cycle wr_en to ch0 div=6 -> ch0 next tick 6 cycles after.
- FREE_W=4 override -> free_wrap high once per 16 cycles, coincident with free_cnt==0; rst asserted mid-count clears all outputs immediately (async), before the next clk edge.
- MULTI_TICKGEN_ONESHOT_EN, ch1 div=4, oneshot[1]=1 -> single tick at cycle 4, done[1]=1 from cycle 5, no tick by cycle 40; sync -> done[1]=0, next tick 4 cycles later.
